// File: rtl/ccl_frame_sequencer.sv
// Frame-level controller for the connected-components labeller: streams one raster frame
// into the labeller with row-end and end-of-frame bubbles, then sweeps obj_id over the labels.
module ccl_frame_sequencer #(
  parameter int WORD      = 8,
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int GAP_LEN   = 4,
  parameter int FLUSH_LEN = WIDTH + 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [WORD-1:0] s_pixel,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [WORD-1:0] label_count,
  output logic            lab_reset_n,
  output logic            en,
  output logic [15:0]     x,
  output logic [15:0]     y,
  output logic [WORD-1:0] p_out,
  output logic [WORD-1:0] obj_id,
  output logic            obj_valid,
  input  logic            obj_ready,
  output logic            frame_busy,
  output logic            frame_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_RUN     = 3'd2,
    S_GAP     = 3'd3,
    S_FLUSH   = 3'd4,
    S_READOUT = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [15:0]     COL_LAST   = 16'(WIDTH - 1);
  localparam logic [15:0]     ROW_LAST   = 16'(HEIGHT - 1);
  localparam logic [15:0]     GAP_LAST   = 16'(GAP_LEN - 1);
  localparam logic [15:0]     FLUSH_LAST = 16'(FLUSH_LEN - 1);
  localparam logic [15:0]     GAP_X0     = 16'(WIDTH);
  localparam logic [15:0]     FLUSH_Y    = 16'(HEIGHT);
  localparam logic [WORD-1:0] LBL_ONE    = WORD'(1);

  state_t          state_q, state_d;
  logic [15:0]     col_q, col_d;
  logic [15:0]     row_q, row_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            en_q, en_d;
  logic [15:0]     x_q, x_d;
  logic [15:0]     y_q, y_d;
  logic [WORD-1:0] p_q, p_d;
  logic [WORD-1:0] obj_id_q, obj_id_d;
  logic            obj_valid_q, obj_valid_d;
  logic [WORD-1:0] n_lab_q, n_lab_d;
  logic            lab_reset_n_q;
  logic            frame_busy_q;
  logic            frame_done_q;
  logic            accept_s;

  assign s_ready  = (state_q == S_RUN);
  assign accept_s = s_valid & s_ready;

  // Next-state and next-output decode
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    en_d        = 1'b0;
    x_d         = x_q;
    y_d         = y_q;
    p_d         = p_q;
    obj_id_d    = obj_id_q;
    obj_valid_d = obj_valid_q;
    n_lab_d     = n_lab_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CLEAR: begin
        col_d   = 16'd0;
        row_d   = 16'd0;
        cnt_d   = 16'd0;
        state_d = S_RUN;
      end

      S_RUN: begin
        if (accept_s) begin
          en_d  = 1'b1;
          p_d   = s_pixel;
          x_d   = col_q;
          y_d   = row_q;
          cnt_d = 16'd0;
          if (col_q == COL_LAST) begin
            col_d = 16'd0;
            if (row_q == ROW_LAST) begin
              state_d = S_FLUSH;
            end else begin
              state_d = S_GAP;
            end
          end else begin
            col_d = col_q + 16'd1;
          end
        end else begin
          en_d = 1'b0;
        end
      end

      // Bubbles keep y on the finished row so its merge stack drains before the parity flips
      S_GAP: begin
        en_d = 1'b1;
        p_d  = '0;
        x_d  = GAP_X0 + cnt_q;
        y_d  = row_q;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = 16'd0;
          row_d   = row_q + 16'd1;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_FLUSH: begin
        en_d = 1'b1;
        p_d  = '0;
        x_d  = cnt_q;
        y_d  = FLUSH_Y;
        if (cnt_q == FLUSH_LAST) begin
          cnt_d   = 16'd0;
          n_lab_d = label_count;
          if (label_count <= LBL_ONE) begin
            state_d = S_DONE;
          end else begin
            obj_id_d    = LBL_ONE;
            obj_valid_d = 1'b1;
            state_d     = S_READOUT;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_READOUT: begin
        if (!obj_valid_q) begin
          state_d = S_DONE;
        end else if (obj_ready) begin
          if (obj_id_q == (n_lab_q - LBL_ONE)) begin
            obj_valid_d = 1'b0;
            state_d     = S_DONE;
          end else begin
            obj_id_d = obj_id_q + LBL_ONE;
          end
        end else begin
          obj_valid_d = obj_valid_q;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; status strobes are decoded from the next state so they align with it
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      col_q         <= 16'd0;
      row_q         <= 16'd0;
      cnt_q         <= 16'd0;
      en_q          <= 1'b0;
      x_q           <= 16'd0;
      y_q           <= 16'd0;
      p_q           <= '0;
      obj_id_q      <= '0;
      obj_valid_q   <= 1'b0;
      n_lab_q       <= '0;
      lab_reset_n_q <= 1'b0;
      frame_busy_q  <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      cnt_q         <= cnt_d;
      en_q          <= en_d;
      x_q           <= x_d;
      y_q           <= y_d;
      p_q           <= p_d;
      obj_id_q      <= obj_id_d;
      obj_valid_q   <= obj_valid_d;
      n_lab_q       <= n_lab_d;
      lab_reset_n_q <= (state_d != S_CLEAR);
      frame_busy_q  <= (state_d != S_IDLE);
      frame_done_q  <= (state_d == S_DONE);
    end
  end

  assign lab_reset_n = lab_reset_n_q;
  assign en          = en_q;
  assign x           = x_q;
  assign y           = y_q;
  assign p_out       = p_q;
  assign obj_id      = obj_id_q;
  assign obj_valid   = obj_valid_q;
  assign frame_busy  = frame_busy_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_ccl_frame_sequencer.sv
// Scoreboard bench for ccl_frame_sequencer on a 4x3 frame: the driver queues expected labeller
// beats and readout ids, a negedge monitor pops and compares them as the DUT emits them.
`timescale 1ns/1ps
module tb_ccl_frame_sequencer;
  localparam int WORD      = 8;
  localparam int WIDTH     = 4;
  localparam int HEIGHT    = 3;
  localparam int GAP_LEN   = 2;
  localparam int FLUSH_LEN = 8;

  typedef struct packed {
    logic [7:0]  p;
    logic [15:0] x;
    logic [15:0] y;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  s_pixel = 8'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  label_count = 8'd0;
  logic        lab_reset_n;
  logic        en;
  logic [15:0] x;
  logic [15:0] y;
  logic [7:0]  p_out;
  logic [7:0]  obj_id;
  logic        obj_valid;
  logic        obj_ready = 1'b0;
  logic        frame_busy;
  logic        frame_done;

  beat_t      exp_beat[$];
  logic [7:0] exp_obj[$];
  int         n_vec = 0;
  int         n_err = 0;

  ccl_frame_sequencer #(
    .WORD(WORD), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .GAP_LEN(GAP_LEN), .FLUSH_LEN(FLUSH_LEN)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .s_pixel(s_pixel), .s_valid(s_valid),
    .s_ready(s_ready), .label_count(label_count), .lab_reset_n(lab_reset_n), .en(en),
    .x(x), .y(y), .p_out(p_out), .obj_id(obj_id), .obj_valid(obj_valid),
    .obj_ready(obj_ready), .frame_busy(frame_busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [7:0] pix_of(input int kind, input int i);
    case (kind)
      0:       return 8'd0;
      1:       return ((i % 3) == 2) ? 8'd0 : 8'(i + 1);
      default: return 8'(8'hA0 + i);
    endcase
  endfunction

  // Monitor: every en beat and every readout handshake must match the queue head
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && en) begin
        if (exp_beat.size() == 0) begin
          check("unexpected_en", {p_out, x, y}, 64'd0);
        end else begin
          check("labeller_beat", {p_out, x, y}, exp_beat.pop_front());
        end
      end
      if (reset_n && obj_valid && obj_ready) begin
        if (exp_obj.size() == 0) begin
          check("unexpected_obj", {56'd0, obj_id}, 64'hFF);
        end else begin
          check("obj_id", {56'd0, obj_id}, {56'd0, exp_obj.pop_front()});
        end
      end
    end
  end

  task automatic run_frame(input int kind, input bit stall, input int lab, input int rdly,
                           input bit ign, input bit rst_gap);
    int wc;
    int k;
    int exp_k;
    for (int r = 0; r < HEIGHT; r++) begin
      for (int c = 0; c < WIDTH; c++)
        exp_beat.push_back('{p: pix_of(kind, r * WIDTH + c), x: 16'(c), y: 16'(r)});
      if (r < HEIGHT - 1)
        for (int g = 0; g < GAP_LEN; g++)
          exp_beat.push_back('{p: 8'd0, x: 16'(WIDTH + g), y: 16'(r)});
    end
    for (int f = 0; f < FLUSH_LEN; f++)
      exp_beat.push_back('{p: 8'd0, x: 16'(f), y: 16'(HEIGHT)});
    for (int o = 1; o < lab; o++) exp_obj.push_back(8'(o));
    label_count = 8'(lab);
    obj_ready   = (rdly == 0);

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("clear_lab_reset_n", {63'd0, lab_reset_n}, 64'd0);
    check("clear_s_ready", {63'd0, s_ready}, 64'd0);
    @(posedge clk); #1;
    check("run_s_ready", {62'd0, s_ready, lab_reset_n}, 64'd3);

    for (int i = 0; i < WIDTH * HEIGHT; i++) begin
      s_valid = 1'b1;
      s_pixel = pix_of(kind, i);
      start   = ign && (i == 5);
      wc = 0;
      while (!s_ready && wc < 50) begin
        @(posedge clk); #1 wc++;
      end
      if (!s_ready) begin
        n_vec++; n_err++;
        $display("FAIL s_ready_timeout: got 0 expected 1 at pixel %0d", i);
        s_valid = 1'b0;
        return;
      end
      if (!stall && i > 0 && (i % WIDTH) == 0) check("gap_ready_low_cycles", 64'(wc), 64'(GAP_LEN));
      @(posedge clk); #1;
      s_valid = 1'b0;
      start   = 1'b0;
      if (ign && i == 5) check("start_ignored_run", {62'd0, lab_reset_n, frame_busy}, 64'd3);
      if (rst_gap && i == 2 * WIDTH - 1) begin
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("midframe_reset_outputs",
              {10'd0, s_ready, lab_reset_n, en, x, y, p_out, obj_id, obj_valid, frame_busy, frame_done},
              64'd0);
        exp_beat.delete();
        exp_obj.delete();
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", {61'd0, lab_reset_n, frame_busy, s_ready}, 64'd4);
        return;
      end
      if (stall && i != WIDTH * HEIGHT - 1) begin
        @(posedge clk); #1;
        if ((i % WIDTH) != WIDTH - 1) begin
          check("stall_en_low", {63'd0, en}, 64'd0);
          check("stall_x_hold", {48'd0, x}, 64'(i % WIDTH));
        end
      end
    end

    k = 0;
    do begin
      @(posedge clk); #1 k++;
      start = 1'b0;
      if (ign && k == FLUSH_LEN + 1) start = 1'b1;
      if (ign && k == FLUSH_LEN + 2) check("start_ignored_readout", {63'd0, lab_reset_n}, 64'd1);
      if (rdly > 0 && k == FLUSH_LEN + rdly) begin
        check("obj_hold_under_backpressure", {55'd0, obj_valid, obj_id}, 64'h101);
        obj_ready = 1'b1;
      end
    end while (!frame_done && k < 200);
    exp_k = (lab > 1) ? FLUSH_LEN + rdly + (lab - 1) : FLUSH_LEN;
    check("frame_done_latency", 64'(k), 64'(exp_k));
    @(posedge clk); #1;
    check("frame_done_pulse", {62'd0, frame_done, frame_busy}, 64'd0);
    check("scoreboard_drained", 64'(exp_beat.size() + exp_obj.size()), 64'd0);
    obj_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {10'd0, s_ready, lab_reset_n, en, x, y, p_out, obj_id, obj_valid, frame_busy, frame_done},
          64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", {61'd0, lab_reset_n, frame_busy, s_ready}, 64'd4);

    run_frame(1, 1'b0, 4, 3, 1'b1, 1'b0);
    run_frame(2, 1'b1, 2, 0, 1'b0, 1'b0);
    run_frame(0, 1'b0, 1, 0, 1'b0, 1'b0);
    run_frame(1, 1'b0, 3, 0, 1'b0, 1'b1);
    run_frame(2, 1'b0, 3, 1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ccl_frame_sequencer.md
# ccl_frame_sequencer

Frame-level controller for the connected-components labeller. It accepts a raster pixel stream and drives the labeller's `en`, `x`, `y` and `p` inputs. It inserts background bubble cycles at each row end so the alternating merge stacks can drain, and flushes the pipeline after the last row. It then sweeps `obj_id` across every allocated label so the downstream feature readout can collect per-object data.

## Interface
Parameters:
- `WORD`, 8: pixel/label width; must match the labeller word size.
- `WIDTH`, 640: pixels per row, 2..65535.
- `HEIGHT`, 480: rows per frame, 1..65535.
- `GAP_LEN`, 4: bubble cycles inserted after each row, ≥1.
- `FLUSH_LEN`, WIDTH+4: bubble cycles after the last row, ≥4.

Ports (reset reset_n, synchronous, active-low; clock clk):
- `clk`, in, 1: clock.
- `reset_n`, in, 1: synchronous active-low reset.
- `start`, in, 1: begin-frame pulse; ignored unless in IDLE.
- `s_pixel`, in, WORD: input pixel; 0 = background.
- `s_valid`, in, 1: `s_pixel` valid.
- `s_ready`, out, 1: sequencer accepts `s_pixel`.
- `label_count`, in, WORD: labeller's next-free label (`num_labels`).
- `lab_reset_n`, out, 1: labeller reset, active-low.
- `en`, out, 1: labeller advance strobe.
- `x`, out, 16: column of the pixel on `p_out`.
- `y`, out, 16: row of the pixel on `p_out`; its LSB is the labeller's stack select.
- `p_out`, out, WORD: pixel to labeller.
- `obj_id`, out, WORD: label being read out.
- `obj_valid`, out, 1: `obj_id` valid.
- `obj_ready`, in, 1: downstream consumed `obj_id`.
- `frame_busy`, out, 1: high in every state except IDLE.
- `frame_done`, out, 1: one-cycle completion pulse.

## Operation
- **States:** IDLE, CLEAR, RUN, GAP, FLUSH, READOUT, DONE.
- **IDLE:**
  - All strobes are low.
  - `start` moves to CLEAR.
- **CLEAR:**
  - Lasts exactly 1 cycle with `lab_reset_n`=0.
  - Internal column/row counters are cleared.
  - Moves to RUN.
- **RUN:**
  - `s_ready`=1.
  - On `s_valid & s_ready`, the pixel is registered onto `p_out`/`x`/`y` with `en`=1 on the next cycle.
  - With no handshake, `en`=0 next cycle and `p_out`/`x`/`y` hold.
  - When the accepted pixel has column WIDTH-1:
    - The column counter wraps to 0.
    - If the row is HEIGHT-1, go to FLUSH.
    - Otherwise, go to GAP.
- **GAP:**
  - `s_ready`=0.
  - Emits GAP_LEN cycles with `en`=1, `p_out`=0, `x`=WIDTH..WIDTH+GAP_LEN-1, and `y` equal to the row just finished.
  - Then the row counter increments and the state returns to RUN.
- **FLUSH:**
  - `s_ready`=0.
  - Emits FLUSH_LEN cycles with `en`=1, `p_out`=0, `x`=0..FLUSH_LEN-1 (16-bit), and `y`=HEIGHT. The row parity flip lets the final row's merges pop.
  - On the last FLUSH cycle, `label_count` is sampled into `n_lab`.
  - If `n_lab` ≤ 1, go to DONE; otherwise set `obj_id`=1, `obj_valid`=1 and go to READOUT.
- **READOUT:**
  - `en`=0.
  - On `obj_valid & obj_ready`:
    - If `obj_id` = `n_lab`-1, drop `obj_valid` and go to DONE.
    - Otherwise increment `obj_id`.
  - While `obj_ready`=0, `obj_id` and `obj_valid` hold.
- **DONE:**
  - `frame_done`=1 for 1 cycle.
  - Returns to IDLE.
- **Boundaries:**
  - `start` outside IDLE is ignored.
  - `s_valid` outside RUN is not accepted.
  - Row/column counters are 16-bit; the maximum WIDTH/HEIGHT fit, so counters never wrap within a frame.
  - Reset in any state returns to IDLE on the next edge. Pixels already in flight are discarded, and the labeller sees `lab_reset_n`=0 during reset.

## Timing
- **Reset values:**
  - `s_ready`=0, `lab_reset_n`=0, `en`=0.
  - `x`=0, `y`=0, `p_out`=0.
  - `obj_id`=0, `obj_valid`=0.
  - `frame_busy`=0, `frame_done`=0.
  - After reset is released, `lab_reset_n`=1 except in CLEAR.
- **Registered outputs:** all outputs are registered except `s_ready`, which is decoded from the state register (RUN only).
- **Pixel latency:** handshake at cycle t → `en`/`p_out`/`x`/`y` valid at t+1.
- **Start latency:** `start` at t → `lab_reset_n`=0 at t+1 (CLEAR) → `s_ready`=1 at t+2.
- **Per-row cost:** WIDTH accepted pixels + GAP_LEN bubbles.
- **Frame minimum cycles** (`s_valid` always high, `obj_ready` always high): 2 + HEIGHT·WIDTH + (HEIGHT-1)·GAP_LEN + FLUSH_LEN + (n_lab-1) + 1.
- **`frame_done` timing:** asserts the cycle after the last readout handshake, or the cycle after FLUSH when `n_lab` ≤ 1.

## Test plan
Scenarios use WIDTH=4, HEIGHT=3, GAP_LEN=2, FLUSH_LEN=8.
- **Nominal frame:** `start`, `s_valid`=1 with 12 pixels → `lab_reset_n` low 1 cycle; `en` high for 12+2·2+8=24 cycles; `y` sequence 0,0,0,0,0,0,1…,2…,3; `s_ready` low during each GAP.
- **Stalls:** `s_valid` toggled 1,0,1,0 in RUN → `en` mirrors the handshakes one cycle later; `x` holds across gaps in `s_valid`; no pixel is lost or duplicated.
- **Readout with backpressure:** `label_count`=4, `obj_ready`=0 for 3 cycles and then 1 → `obj_id`=1 holds for 3 cycles, then 1,2,3; `frame_done` one cycle after `obj_id`=3 is accepted.
- **Empty frame:** all pixels 0, `label_count`=1 → no `obj_valid`; `frame_done` the cycle after the last FLUSH cycle.
- **Reset mid-frame:** `reset_n` low during the second GAP → next cycle every output is at its reset value, state IDLE; a subsequent `start` runs a full clean frame.
- **Ignored start:** `start` pulsed during RUN and during READOUT → no CLEAR, no change to the counters.
